// File: rtl/seq_control_unit_if.sv
// Shared ISA types and the bus bundle between the sequencer and its datapath,
// register file, instruction source and data memory.
package seq_control_unit_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_MOV  = 5'd6,
    OP_CMP  = 5'd7,
    OP_LDM  = 5'd8,
    OP_STR  = 5'd9,
    OP_STD  = 5'd10,
    OP_PSHR = 5'd11,
    OP_PSHD = 5'd12,
    OP_POP  = 5'd13,
    OP_CALL = 5'd14,
    OP_RET  = 5'd15,
    OP_JMP  = 5'd16,
    OP_JMPR = 5'd17,
    OP_JZD  = 5'd18,
    OP_JCD  = 5'd19,
    OP_JND  = 5'd20,
    OP_JVD  = 5'd21,
    OP_HALT = 5'd22
  } opcodes_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } flags_t;

  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} mem_ops_t;

  typedef enum logic [2:0] {
    ALU_NOP    = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_PASS_B = 3'd6,
    ALU_INC    = 3'd7
  } alu_ops_t;

  typedef enum logic [1:0] {SRC_NONE = 2'd0, SRC_REG = 2'd1, SRC_IMM = 2'd2, SRC_PC = 2'd3} data_source_t;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM_WAIT  = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

endpackage

// Handshakes: an instruction transfers on a cycle where fetch_req and
// instr_valid are both 1; a memory access transfers on a cycle where mem_op is
// not NOP and mem_ready is 1, and mem_op is held stable until that cycle.
interface seq_control_unit_if #(
  parameter int WORD_W = 8,
  parameter int REG_AW = 2
);
  import seq_control_unit_pkg::*;

  logic              fetch_req;
  logic              instr_valid;
  opcodes_t          instr_opcode;
  logic [WORD_W-1:0] instr_dest;
  logic [WORD_W-1:0] instr_src;
  logic [WORD_W-1:0] pc;
  flags_t            flags_in;
  logic              update_flags;
  logic [WORD_W-1:0] rf_read_data_a;
  logic [REG_AW-1:0] rf_read_addr_a;
  logic [REG_AW-1:0] rf_read_addr_b;
  logic              rf_write_enable;
  logic [REG_AW-1:0] rf_write_addr;
  logic [WORD_W-1:0] mem_rw_addr;
  mem_ops_t          mem_op;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_read_data;
  alu_ops_t          alu_op;
  data_source_t      alu_a_src_sel;
  data_source_t      alu_b_src_sel;
  logic [2:0]        state;
  logic              halted;
  logic              fault;
  logic              resume;

  modport master (
    output fetch_req, pc, rf_read_addr_a, rf_read_addr_b, rf_write_enable, rf_write_addr,
           mem_rw_addr, mem_op, alu_op, alu_a_src_sel, alu_b_src_sel, state, halted, fault,
    input  instr_valid, instr_opcode, instr_dest, instr_src, flags_in, update_flags,
           rf_read_data_a, mem_ready, mem_read_data, resume
  );

  modport slave (
    input  fetch_req, pc, rf_read_addr_a, rf_read_addr_b, rf_write_enable, rf_write_addr,
           mem_rw_addr, mem_op, alu_op, alu_a_src_sel, alu_b_src_sel, state, halted, fault,
    output instr_valid, instr_opcode, instr_dest, instr_src, flags_in, update_flags,
           rf_read_data_a, mem_ready, mem_read_data, resume
  );

endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/mem-wait/writeback with a
// descending hardware stack. Define SEQ_STACK_GUARD_EN to trap stack overflow/underflow.
module seq_control_unit
  import seq_control_unit_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int REG_AW      = 2,
  parameter int STACK_TOP   = 255,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_control_unit_if.master bus
);

  localparam logic [WORD_W-1:0] SP_EMPTY = WORD_W'(STACK_TOP);
  localparam logic [WORD_W-1:0] SP_SPAN  = WORD_W'(STACK_DEPTH);
  localparam logic [WORD_W-1:0] ONE      = WORD_W'(1);

  state_t            state_q, state_d;
  opcodes_t          op_q;
  logic [WORD_W-1:0] dest_q, src_q;
  logic [WORD_W-1:0] pc_q, sp_q;
  logic [WORD_W-1:0] jmpr_q, ret_q;
  logic [WORD_W-1:0] mem_addr_q;
  logic [REG_AW-1:0] rd_a_q, rd_b_q;
  flags_t            flags_q;
  logic              run_q;

  logic              is_alu, is_mem, is_read, is_write, is_push, is_pop, jump_taken;
  logic              stack_full, stack_empty;
  logic [WORD_W-1:0] pc_next;

  assign stack_full  = (SP_EMPTY - sp_q) == SP_SPAN;
  assign stack_empty = (sp_q == SP_EMPTY);

`ifdef SEQ_STACK_GUARD_EN
  logic stack_err;
  assign stack_err = (is_push && stack_full) || (is_pop && stack_empty);
`endif

  // Opcode classification of the latched instruction.
  always_comb begin
    is_alu     = 1'b0;
    is_mem     = 1'b0;
    is_read    = 1'b0;
    is_write   = 1'b0;
    is_push    = 1'b0;
    is_pop     = 1'b0;
    jump_taken = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: begin
        is_alu   = 1'b1;
        is_write = 1'b1;
      end
      OP_CMP: is_alu = 1'b1;
      OP_LDM: begin
        is_mem   = 1'b1;
        is_read  = 1'b1;
        is_write = 1'b1;
      end
      OP_STR, OP_STD: is_mem = 1'b1;
      OP_PSHR, OP_PSHD, OP_CALL: begin
        is_mem  = 1'b1;
        is_push = 1'b1;
      end
      OP_POP: begin
        is_mem   = 1'b1;
        is_read  = 1'b1;
        is_pop   = 1'b1;
        is_write = 1'b1;
      end
      OP_RET: begin
        is_mem  = 1'b1;
        is_read = 1'b1;
        is_pop  = 1'b1;
      end
      OP_JMP, OP_JMPR: jump_taken = 1'b1;
      OP_JZD: jump_taken = flags_q.zero;
      OP_JCD: jump_taken = flags_q.carry;
      OP_JND: jump_taken = flags_q.negative;
      OP_JVD: jump_taken = flags_q.overflow;
      default: ;
    endcase
  end

  always_comb begin
    pc_next = pc_q + ONE;
    if (op_q == OP_CALL)     pc_next = dest_q;
    else if (op_q == OP_RET) pc_next = ret_q;
    else if (jump_taken)     pc_next = (op_q == OP_JMPR) ? jmpr_q : dest_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (run_q && bus.instr_valid) state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = is_mem ? ST_MEM_WAIT : ST_WRITEBACK;
`ifdef SEQ_STACK_GUARD_EN
        if (stack_err) state_d = ST_FAULT;
`endif
      end
      ST_MEM_WAIT:  if (bus.mem_ready) state_d = ST_WRITEBACK;
      ST_WRITEBACK: state_d = (op_q == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:      if (bus.resume) state_d = ST_FETCH;
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_FETCH;
    endcase
  end

  // run_q holds fetch_req low for the reset cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      op_q    <= OP_NOP;
      dest_q  <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      sp_q    <= SP_EMPTY;
      jmpr_q  <= '0;
      ret_q   <= '0;
      flags_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (bus.update_flags) flags_q <= bus.flags_in;
      case (state_q)
        ST_FETCH: begin
          if (run_q && bus.instr_valid) begin
            op_q   <= bus.instr_opcode;
            dest_q <= bus.instr_dest;
            src_q  <= bus.instr_src;
          end
        end
        ST_EXECUTE: jmpr_q <= bus.rf_read_data_a;
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            ret_q <= bus.mem_read_data;
            // A full push / empty pop reuses the current SP instead of wrapping.
            if (is_push && !stack_full)     sp_q <= sp_q - ONE;
            else if (is_pop && !stack_empty) sp_q <= sp_q + ONE;
          end
        end
        ST_WRITEBACK: pc_q <= pc_next;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      mem_addr_q <= '0;
    end else if (state_q == ST_DECODE) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      mem_addr_q <= '0;
      if (is_alu) rd_a_q <= dest_q[REG_AW-1:0];
      case (op_q)
        OP_LDM: mem_addr_q <= src_q;
        OP_STR: begin
          mem_addr_q <= dest_q;
          rd_b_q     <= src_q[REG_AW-1:0];
        end
        OP_STD: mem_addr_q <= dest_q;
        OP_PSHR: begin
          mem_addr_q <= sp_q;
          rd_a_q     <= dest_q[REG_AW-1:0];
        end
        OP_PSHD, OP_CALL: mem_addr_q <= sp_q;
        OP_POP, OP_RET:   mem_addr_q <= stack_empty ? sp_q : sp_q + ONE;
        OP_JMPR:          rd_a_q <= dest_q[REG_AW-1:0];
        default: ;
      endcase
    end else if (state_d == ST_FETCH) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      mem_addr_q <= '0;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.rf_read_addr_a = rd_a_q;
  assign bus.rf_read_addr_b = rd_b_q;
  assign bus.mem_rw_addr    = mem_addr_q;

  always_comb begin
    bus.fetch_req       = (state_q == ST_FETCH) && run_q;
    bus.state           = state_q;
    bus.halted          = (state_q == ST_HALT);
`ifdef SEQ_STACK_GUARD_EN
    bus.fault           = (state_q == ST_FAULT);
`else
    bus.fault           = 1'b0;
`endif
    bus.mem_op          = MEM_NOP;
    bus.alu_op          = ALU_NOP;
    bus.alu_a_src_sel   = SRC_NONE;
    bus.alu_b_src_sel   = SRC_NONE;
    bus.rf_write_enable = 1'b0;
    bus.rf_write_addr   = '0;
    if (state_q == ST_MEM_WAIT) bus.mem_op = is_read ? MEM_READ : MEM_WRITE;
    // ALU controls stay stable from EXECUTE until WRITEBACK completes; CALL uses the ALU to form pc+1.
    if (state_q == ST_EXECUTE || state_q == ST_MEM_WAIT || state_q == ST_WRITEBACK) begin
      case (op_q)
        OP_ADD: begin bus.alu_op = ALU_ADD; bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_SUB: begin bus.alu_op = ALU_SUB; bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_CMP: begin bus.alu_op = ALU_SUB; bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_AND: begin bus.alu_op = ALU_AND; bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_OR:  begin bus.alu_op = ALU_OR;  bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_XOR: begin bus.alu_op = ALU_XOR; bus.alu_a_src_sel = SRC_REG; bus.alu_b_src_sel = SRC_IMM; end
        OP_MOV: begin bus.alu_op = ALU_PASS_B; bus.alu_b_src_sel = SRC_IMM; end
        OP_CALL: begin bus.alu_op = ALU_INC; bus.alu_a_src_sel = SRC_PC; end
        default: ;
      endcase
    end
    if (state_q == ST_WRITEBACK && is_write) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_write_addr   = dest_q[REG_AW-1:0];
    end
  end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameter WORD_W, default 8, data/address/PC width.
REQ-002 Parameter REG_AW, default 2, register-file address width.
REQ-003 Parameter STACK_TOP, default 255, stack base address (empty SP value).
REQ-004 Parameter STACK_DEPTH, default 16, max pushed entries.
REQ-005 Ports (name dir width meaning):
 - clk in 1: clock; all state on rising edge.
 - reset_n in 1: asynchronous, active-low reset.
 - fetch_req out 1: instruction fetch request.
 - instr_valid in 1: opcode/dest/src valid.
 - instr_opcode in OPCODES_T: opcode.
 - instr_dest in WORD_W: operand A.
 - instr_src in WORD_W: operand B.
 - pc out WORD_W: program counter.
 - flags_in in FLAGS_T: ALU flags; update_flags in 1: capture strobe.
 - rf_read_data_a in WORD_W: register A data.
 - rf_read_addr_a, rf_read_addr_b out REG_AW: read addresses.
 - rf_write_enable out 1; rf_write_addr out REG_AW: write port.
 - mem_rw_addr out WORD_W; mem_op out MEM_OPS_T: data memory request.
 - mem_ready in 1: memory completion; mem_read_data in WORD_W: read data.
 - alu_op out ALU_OPS_T; alu_a_src_sel, alu_b_src_sel out DATA_SOURCE_T.
 - state out 3: encoded FSM state; halted out 1; fault out 1; resume in 1.

Function
REQ-006 FSM states SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM_WAIT=3, WRITEBACK=4, HALT=5, FAULT=6.
REQ-007 FETCH SHALL assert fetch_req and stay until instr_valid=1, then latch opcode/dest/src and go to DECODE.
REQ-008 DECODE SHALL last one cycle, register rf_read_addr_a/b and mem_rw_addr per opcode class, then go to EXECUTE.
REQ-009 EXECUTE SHALL drive alu_op/src selects for ALU opcodes, held until WRITEBACK ends; non-memory opcodes go to WRITEBACK next cycle.
REQ-010 Memory opcodes (LDM, STR, STD, PSHR, PSHD, POP, CALL, RET) SHALL go to MEM_WAIT with mem_op held READ/WRITE until mem_ready=1, then WRITEBACK; mem_op SHALL be NOP the cycle after.
REQ-011 WRITEBACK SHALL last one cycle; write-class opcodes (as existing ISA plus POP) assert rf_write_enable with rf_write_addr=instr_dest[REG_AW-1:0].
REQ-012 WRITEBACK SHALL set pc to pc+1 (modulo 2^WORD_W) unless a taken jump, CALL (pc=instr_dest) or RET (pc=captured mem_read_data).
REQ-013 Conditional jumps SHALL use the registered flags; update_flags in the same WRITEBACK cycle affects only the next instruction.
REQ-014 PSHR/PSHD/CALL SHALL write at SP then decrement SP; POP/RET SHALL increment SP then read at new SP.
REQ-015 CALL SHALL push pc+1; RET SHALL load pc from popped word.
REQ-016 Stack full is STACK_TOP-SP==STACK_DEPTH; empty is SP==STACK_TOP.
REQ-017 HALT opcode SHALL enter HALT after WRITEBACK with pc already incremented; halted=1; resume=1 returns to FETCH next cycle.
REQ-018 resume outside HALT SHALL be ignored.
REQ-019 All control outputs (addresses, mem_op, alu_*) SHALL return to zero/NOP on entering FETCH.

Reset
REQ-020 reset_n=0 SHALL immediately force state=FETCH, pc=0, SP=STACK_TOP, flags=0, mem_op=NOP, alu_op=NOP, all addresses 0, rf_write_enable=0, fetch_req=0, halted=0, fault=0.
REQ-021 Reset asserted mid-MEM_WAIT SHALL abandon the access with no PC/SP change surviving.
REQ-022 First fetch_req SHALL assert the first clk edge after reset_n deasserts.

Configuration
REQ-023 Macro SEQ_STACK_GUARD_EN defined: push when full or pop when empty SHALL enter FAULT (fault=1, no memory op, sticky until reset).
REQ-024 Macro undefined: push when full SHALL write at SP without decrement; pop when empty SHALL read at SP without increment; fault tied 0.

Verification
REQ-025 Reset, instr_valid held low 5 cycles -> fetch_req high, state=FETCH, pc=0 throughout.
REQ-026 ADD r1,#5 with instr_valid immediate -> WRITEBACK on cycle 4, rf_write_enable=1, rf_write_addr=1, pc 0->1.
REQ-027 LDM r2,[0x40], mem_ready after 3 wait cycles -> mem_op=READ 4 cycles, mem_rw_addr=0x40, then write r2, pc+1.
REQ-028 CALL 0x20 at pc=0x10 then RET -> write 0x11 at 0xFF, SP 0xFF->0xFE, pc=0x20; RET restores pc=0x11, SP=0xFF.
REQ-029 17 PSHD with guard defined -> 17th enters FAULT, fault=1; undefined -> 17th writes 0xEF, SP stays 0xEF.
REQ-030 JZD 0x30 with flags.zero=0, update_flags carrying zero=1 in same WRITEBACK -> not taken, pc+1; HALT then resume pulse -> FETCH next cycle.
